// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode/funct, ALU and mux-select encodings for the multicycle MIPS controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXEC, S_RTWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [1:0] SA_PC = 2'd0;
  localparam logic [1:0] SA_RS = 2'd1;
  localparam logic [1:0] SA_RT = 2'd2;
  localparam logic [1:0] SB_RT      = 2'd0;
  localparam logic [1:0] SB_FOUR    = 2'd1;
  localparam logic [1:0] SB_IMM     = 2'd2;
  localparam logic [1:0] SB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
endpackage

// File: rtl/mc_control_fsm_alu_decode.sv
// mc_alu_decode: R-type funct to alu_control map, flagging shifts and unsupported funct codes
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_shift,
  output logic       o_illegal
);
  always_comb begin
    o_alu_control = i_funct == FN_ADD ? ALU_ADD :
                    i_funct == FN_SUB ? ALU_SUB :
                    i_funct == FN_AND ? ALU_AND :
                    i_funct == FN_OR  ? ALU_OR  :
                    i_funct == FN_SLT ? ALU_SLT :
                    i_funct == FN_SLL ? ALU_SLL :
                    i_funct == FN_SRL ? ALU_SRL : ALU_ADD;
    o_shift   = i_funct == FN_SLL || i_funct == FN_SRL;
    o_illegal = !(i_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL});
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS sequencer with memory ready handshake and wait timeout.
// Optional MC_PERF_COUNTERS_EN adds cycle_count / retired_count outputs.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        mem_timeout,
`ifdef MC_PERF_COUNTERS_EN
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count,
`endif
  output logic [3:0]  state
);
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);
  state_t          r_state;
  logic [WW-1:0]   r_wait;
  logic            r_timeout;
  logic            r_illegal;
  state_t          w_next;
  state_t          w_dispatch;
  logic            w_illegal;
  logic            w_mem_state;
  logic            w_wait_hit;
  logic [3:0]      w_alu;
  logic            w_shift;
  logic            w_bad_funct;
  mc_alu_decode u_alu_decode (
    .i_funct      (funct),
    .o_alu_control(w_alu),
    .o_shift      (w_shift),
    .o_illegal    (w_bad_funct)
  );
  assign w_mem_state = r_state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign w_wait_hit  = w_mem_state && !mem_ready && r_wait == WAIT_LAST;
  assign w_dispatch  = opcode == OP_RTYPE               ? S_RTEXEC :
                       opcode == OP_LW || opcode == OP_SW ? S_MEMADR :
                       opcode == OP_BEQ                 ? S_BRANCH :
                       opcode == OP_ADDI                ? S_ADDIEX :
                       opcode == OP_J                   ? S_JUMP   : S_FETCH;
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next    = w_dispatch;
        w_illegal = w_dispatch == S_FETCH;
      end
      S_MEMADR: w_next = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXEC: begin
        w_next    = w_bad_funct ? S_FETCH : S_RTWB;
        w_illegal = w_bad_funct;
      end
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
    if (w_wait_hit) w_next = S_FETCH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= (!w_mem_state || mem_ready || w_wait_hit) ? '0 : r_wait + 1'b1;
      r_timeout <= r_timeout | w_wait_hit;
      r_illegal <= w_illegal;
    end
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PC_ALU;
    alu_src_a   = SA_PC;
    alu_src_b   = SB_RT;
    alu_control = ALU_ADD;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = SB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = SA_RS;
        alu_src_b = SB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_RTEXEC: begin
        alu_src_a   = w_shift ? SA_RT : SA_RS;
        alu_control = w_alu;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = SA_RS;
        alu_control = ALU_SUB;
        pc_src      = PC_ALUOUT;
        pc_en       = zero;
      end
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // reset forces FETCH, but nothing may strobe the datapath until it is released
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
    end
  end
  assign illegal     = r_illegal;
  assign mem_timeout = r_timeout;
  assign state       = r_state;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_retired_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cycle_count   <= '0;
      r_retired_count <= '0;
    end else begin
      r_cycle_count   <= r_cycle_count + 32'd1;
      r_retired_count <= r_retired_count + 32'(
        r_state inside {S_MEMWB, S_MEMWR, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP} &&
        w_next == S_FETCH && !w_wait_hit);
    end
  assign cycle_count   = r_cycle_count;
  assign retired_count = r_retired_count;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed stimulus pushes per-cycle expectations; a negedge monitor pops and compares
module tb_mc_control_fsm;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write, reg_dst, mem_to_reg, illegal, mem_timeout;
  logic [1:0] pc_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control, state;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_count, retired_count;
`endif
  localparam int F_ST = 0, F_RW = 1, F_RD = 2, F_ALU = 3, F_PCEN = 4, F_PCSRC = 5, F_IORD = 6,
                 F_ILL = 7, F_TO = 8, F_M2R = 9, F_REQ = 10, F_WE = 11, F_IRW = 12, F_SA = 13, F_SB = 14;
  typedef struct {int cyc; string nm; int fld; logic [3:0] v;} exp_t;
  exp_t q[$];
  exp_t e;
  int   cyc = 0, n_cmp = 0, n_bad = 0;
  mc_control_fsm #(.MEM_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .mem_timeout(mem_timeout),
`ifdef MC_PERF_COUNTERS_EN
    .cycle_count(cycle_count), .retired_count(retired_count),
`endif
    .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [3:0] field(int f);
    case (f)
      F_ST:    return state;
      F_RW:    return {3'b0, reg_write};
      F_RD:    return {3'b0, reg_dst};
      F_ALU:   return alu_control;
      F_PCEN:  return {3'b0, pc_en};
      F_PCSRC: return {2'b0, pc_src};
      F_IORD:  return {3'b0, iord};
      F_ILL:   return {3'b0, illegal};
      F_TO:    return {3'b0, mem_timeout};
      F_M2R:   return {3'b0, mem_to_reg};
      F_REQ:   return {3'b0, mem_req};
      F_WE:    return {3'b0, mem_we};
      F_IRW:   return {3'b0, ir_write};
      F_SA:    return {2'b0, alu_src_a};
      F_SB:    return {2'b0, alu_src_b};
      default: return 4'hx;
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (field(e.fld) !== e.v) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got %0h expected %0h", e.nm, e.cyc, field(e.fld), e.v);
      end
    end
  task automatic ex(input string nm, input int fld, input logic [3:0] v);
    q.push_back('{cyc, nm, fld, v});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick; tick;
    ex("rst_state", F_ST, 4'd0); ex("rst_req", F_REQ, 0); ex("rst_pcen", F_PCEN, 0);
    ex("rst_irw", F_IRW, 0); ex("rst_to", F_TO, 0); ex("rst_ill", F_ILL, 0); ex("rst_rw", F_RW, 0);
    // add
    tick; reset = 1'b0; opcode = 6'b000000; funct = 6'b100000;
    ex("add_f_st", F_ST, 4'd0); ex("add_f_irw", F_IRW, 1); ex("add_f_pcen", F_PCEN, 1);
    ex("add_f_alu", F_ALU, 4'b0010); ex("add_f_sb", F_SB, 1); ex("add_f_req", F_REQ, 1);
    tick; ex("add_d_st", F_ST, 4'd1); ex("add_d_sb", F_SB, 3);
    tick; ex("add_x_st", F_ST, 4'd6); ex("add_x_alu", F_ALU, 4'b0010); ex("add_x_sa", F_SA, 1);
    ex("add_x_sb", F_SB, 0); ex("add_x_rw", F_RW, 0);
    tick; ex("add_w_st", F_ST, 4'd7); ex("add_w_rw", F_RW, 1); ex("add_w_rd", F_RD, 1); ex("add_w_m2r", F_M2R, 0);
    // lw with three wait states
    tick; opcode = 6'b100011;
    ex("lw_f_st", F_ST, 4'd0); ex("lw_f_rw", F_RW, 0);
    tick; mem_ready = 1'b0; ex("lw_d_st", F_ST, 4'd1); ex("lw_d_rw", F_RW, 0);
    tick; ex("lw_a_st", F_ST, 4'd2); ex("lw_a_sa", F_SA, 1); ex("lw_a_sb", F_SB, 2); ex("lw_a_rw", F_RW, 0);
    for (int i = 0; i < 3; i++) begin
      tick; ex("lw_wait_st", F_ST, 4'd3); ex("lw_wait_iord", F_IORD, 1);
      ex("lw_wait_req", F_REQ, 1); ex("lw_wait_rw", F_RW, 0);
    end
    tick; mem_ready = 1'b1; ex("lw_rd_st", F_ST, 4'd3); ex("lw_rd_iord", F_IORD, 1); ex("lw_rd_rw", F_RW, 0);
    tick; ex("lw_wb_st", F_ST, 4'd4); ex("lw_wb_rw", F_RW, 1); ex("lw_wb_m2r", F_M2R, 1); ex("lw_wb_rd", F_RD, 0);
    // beq taken, then not taken
    tick; opcode = 6'b000100; zero = 1'b1; ex("beq1_f_st", F_ST, 4'd0);
    tick; ex("beq1_d_st", F_ST, 4'd1);
    tick; ex("beq1_b_st", F_ST, 4'd10); ex("beq1_pcen", F_PCEN, 1); ex("beq1_pcsrc", F_PCSRC, 1); ex("beq1_alu", F_ALU, 4'b0110);
    tick; zero = 1'b0; ex("beq0_f_st", F_ST, 4'd0);
    tick; ex("beq0_d_st", F_ST, 4'd1);
    tick; ex("beq0_b_st", F_ST, 4'd10); ex("beq0_pcen", F_PCEN, 0); ex("beq0_pcsrc", F_PCSRC, 1); ex("beq0_alu", F_ALU, 4'b0110);
    // j
    tick; opcode = 6'b000010; ex("j_f_st", F_ST, 4'd0);
    tick; ex("j_d_st", F_ST, 4'd1);
    tick; ex("j_j_st", F_ST, 4'd11); ex("j_pcen", F_PCEN, 1); ex("j_pcsrc", F_PCSRC, 2);
    // illegal opcode, then illegal funct
    tick; opcode = 6'b111111; ex("ilop_f_st", F_ST, 4'd0); ex("ilop_f_ill", F_ILL, 0);
    tick; ex("ilop_d_st", F_ST, 4'd1); ex("ilop_d_ill", F_ILL, 0);
    tick; opcode = 6'b000000; funct = 6'b111111;
    ex("ilop_back_st", F_ST, 4'd0); ex("ilop_pulse", F_ILL, 1); ex("ilop_rw", F_RW, 0);
    tick; ex("ilfn_d_st", F_ST, 4'd1); ex("ilfn_d_ill", F_ILL, 0);
    tick; ex("ilfn_x_st", F_ST, 4'd6); ex("ilfn_x_rw", F_RW, 0); ex("ilfn_x_ill", F_ILL, 0);
    tick; opcode = 6'b100011;
    ex("ilfn_back_st", F_ST, 4'd0); ex("ilfn_pulse", F_ILL, 1); ex("ilfn_rw", F_RW, 0);
    // reset while in MEMRD
    tick; ex("rmid_d_st", F_ST, 4'd1); ex("rmid_d_ill", F_ILL, 0);
    tick; mem_ready = 1'b0; ex("rmid_a_st", F_ST, 4'd2);
    tick; ex("rmid_rd_st", F_ST, 4'd3);
    @(negedge clk); #1; reset = 1'b1; mem_ready = 1'b1;
    tick; ex("rmid_st", F_ST, 4'd0); ex("rmid_rw", F_RW, 0); ex("rmid_req", F_REQ, 0); ex("rmid_to", F_TO, 0);
    // sw stuck on mem_ready=0 until timeout
    tick; reset = 1'b0; opcode = 6'b101011;
    ex("rel_st", F_ST, 4'd0); ex("rel_rw", F_RW, 0); ex("rel_to", F_TO, 0); ex("rel_irw", F_IRW, 1);
    tick; mem_ready = 1'b0; ex("sw_d_st", F_ST, 4'd1); ex("sw_d_rw", F_RW, 0);
    tick; ex("sw_a_st", F_ST, 4'd2);
    for (int i = 0; i < 4; i++) begin
      tick; ex("sw_wait_st", F_ST, 4'd5); ex("sw_wait_we", F_WE, 1); ex("sw_wait_req", F_REQ, 1);
      ex("sw_wait_iord", F_IORD, 1); ex("sw_wait_to", F_TO, 0);
    end
    tick; ex("to_st", F_ST, 4'd0); ex("to_flag", F_TO, 1); ex("to_we", F_WE, 0);
    tick; ex("to_sticky_st", F_ST, 4'd0); ex("to_sticky", F_TO, 1);
    tick; tick;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
